// File: rtl/ste_dma_pkg.sv
// Shared types and constants for the STE DMA data path.
package ste_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // A1 register select
    localparam logic REG_COUNT = 1'b0;
    localparam logic REG_MODE  = 1'b1;

    // status word bit positions (bit0 is the STE inverted error flag)
    localparam int ST_NERR  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_CNT   = 2;

    // direction bit in the mode register: 0 = device->memory, 1 = memory->device
    localparam int DIR_BIT = 8;

endpackage

// File: rtl/ste_dma_wfifo.sv
// Synchronous word FIFO with flush; push and pop may occur in the same cycle.
module ste_dma_wfifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_level;
    logic          w_push, w_pop;

    // a push into a full FIFO is only legal when a pop frees the slot this cycle
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_din;
    end

    // pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_level = r_level;
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/ste_dma_fifo.sv
// STE-style DMA: byte device port <-> word FIFO <-> 16-bit MCU bus with RDY bursts.
module ste_dma_fifo
    import ste_dma_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BURST = 8,
    parameter int CW    = 16
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        FCS_N,
    input  logic        RW,
    input  logic        A1,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        RDY_O,
    input  logic        RDY_I,
    input  logic        dev_in_valid,
    input  logic [7:0]  dev_in_data,
    output logic        dev_in_ready,
    output logic        dev_out_valid,
    output logic [7:0]  dev_out_data,
    input  logic        dev_out_ready,
    input  logic        dev_eot,
    output logic        irq
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(BURST + 1);

    state_t        r_state, w_state_nxt;
    logic          r_dir, r_err, r_eot_seen, r_xfer_seen, r_hi_vld, r_lo_sel;
    logic [7:0]    r_hi;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_bcnt;

    logic          w_reg_rd, w_mode_wr, w_cnt_wr, w_busy, w_strobe, w_xfer_ok, w_xfer_err;
    logic          w_in_acc, w_dev_push, w_out_take, w_dev_pop, w_push, w_pop, w_req, w_exit;
    logic          w_full, w_empty;
    logic [15:0]   w_dev_word, w_push_data, w_head, w_status;
    logic [LW-1:0] w_level, w_level_nxt;
    logic [31:0]   w_lvl32, w_free32, w_cnt32;

    assign w_reg_rd  = clk_en && !FCS_N && RW;
    assign w_mode_wr = clk_en && !FCS_N && !RW && (A1 == REG_MODE);
    assign w_cnt_wr  = clk_en && !FCS_N && !RW && (A1 == REG_COUNT);
    assign w_busy    = (r_state != ST_IDLE);

    // a register write on the same bus cycle wins over the word transfer;
    // strobes outside a granted burst are protocol errors
    assign w_strobe   = clk_en && !RDY_I && !w_mode_wr && !w_cnt_wr;
    assign w_xfer_ok  = w_strobe && w_busy && (r_count != '0) && (r_dir ? !w_full : !w_empty);
    assign w_xfer_err = w_strobe && !w_xfer_ok;

    // device side: second byte or end-of-transfer completes a word
    assign w_in_acc   = dev_in_valid && dev_in_ready;
    assign w_dev_push = !r_dir && !w_full &&
                        (w_in_acc ? (r_hi_vld || dev_eot) : (dev_eot && r_hi_vld));
    assign w_dev_word = r_hi_vld ? {r_hi, (w_in_acc ? dev_in_data : 8'h00)}
                                 : {dev_in_data, 8'h00};
    assign w_out_take = dev_out_valid && dev_out_ready;
    assign w_dev_pop  = w_out_take && r_lo_sel;

    assign w_push      = w_dev_push || (w_xfer_ok && r_dir);
    assign w_pop       = w_dev_pop  || (w_xfer_ok && !r_dir);
    assign w_push_data = r_dir ? DIN : w_dev_word;
    assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);

    assign w_lvl32  = 32'(w_level);
    assign w_free32 = 32'(DEPTH) - w_lvl32;
    assign w_cnt32  = 32'(r_count);

    assign w_req = (r_count != '0) &&
                   (!r_dir ? ((w_lvl32 >= 32'(BURST)) || ((w_lvl32 != 0) && r_eot_seen))
                           : ((w_free32 >= 32'(BURST)) ||
                              ((w_cnt32 < 32'(BURST)) && (w_free32 >= w_cnt32))));

    // burst ends on the transfer that fills the burst, drains the count or empties the FIFO
    assign w_exit = (32'(r_bcnt) + 32'd1 >= 32'(BURST)) || (r_count == CW'(1)) ||
                    (!r_dir && (w_level_nxt == '0));

    ste_dma_wfifo #(.DEPTH(DEPTH), .W(16)) u_wfifo (
        .clk     (clk32),
        .reset   (reset),
        .i_flush (w_mode_wr),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // request FSM next state; a mode write always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (clk_en) begin
            case (r_state)
                ST_IDLE:  if (w_req) w_state_nxt = ST_REQ;
                ST_REQ, ST_BURST:
                    if (w_xfer_ok) w_state_nxt = w_exit ? ST_IDLE : ST_BURST;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_mode_wr) w_state_nxt = ST_IDLE;
    end

    // FSM state register
    always_ff @(posedge clk32) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // mode/count registers, error flag and beat counter within the burst
    always_ff @(posedge clk32) begin
        if (reset) begin
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_xfer_seen <= 1'b0;
            r_bcnt      <= '0;
        end else begin
            if (w_mode_wr) begin
                r_dir <= DIN[DIR_BIT];
                r_err <= 1'b0;
            end else if (w_xfer_err) begin
                r_err <= 1'b1;
            end
            if (w_cnt_wr) begin
                r_count     <= DIN[CW-1:0];
                r_xfer_seen <= 1'b0;
            end else if (w_xfer_ok) begin
                r_count     <= r_count - CW'(1);
                r_xfer_seen <= 1'b1;
            end
            if (!w_busy || w_mode_wr) r_bcnt <= '0;
            else if (w_xfer_ok)       r_bcnt <= r_bcnt + BW'(1);
        end
    end

    // byte packer, unpacker byte select and end-of-transfer tracking
    always_ff @(posedge clk32) begin
        if (reset || w_mode_wr) begin
            r_hi       <= '0;
            r_hi_vld   <= 1'b0;
            r_lo_sel   <= 1'b0;
            r_eot_seen <= 1'b0;
        end else begin
            if (w_dev_push) begin
                r_hi_vld <= 1'b0;
            end else if (w_in_acc) begin
                r_hi     <= dev_in_data;
                r_hi_vld <= 1'b1;
            end
            if (w_out_take) r_lo_sel <= ~r_lo_sel;
            if (w_level_nxt == '0)      r_eot_seen <= 1'b0;
            else if (dev_eot && !r_dir) r_eot_seen <= 1'b1;
        end
    end

    // bus read data: register readback, else head word while serving a read burst
    always_comb begin
        w_status           = '0;
        w_status[ST_CNT]   = (r_count != '0);
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_NERR]  = ~r_err;
        DOUT = 16'h0000;
        if (w_reg_rd)             DOUT = (A1 == REG_MODE) ? w_status : 16'(r_count);
        else if (w_busy && !r_dir) DOUT = w_head;
    end

    assign RDY_O         = !w_busy;
    assign dev_in_ready  = !reset && !r_dir && !w_full;
    assign dev_out_valid = !reset && r_dir && !w_empty;
    assign dev_out_data  = r_lo_sel ? w_head[7:0] : w_head[15:8];
    assign irq           = r_xfer_seen && (r_count == '0);

endmodule
